bitcount_scheduler: RTL and testbench



---
 rtl/bitcount_scheduler_if.sv | 30 +++
 rtl/bitcount_scheduler.sv | 128 ++++++++++++
 tb/tb_bitcount_scheduler.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bitcount_scheduler_if.sv
// Requester-side bus of the popcount scheduler: request levels, operands,
// per-requester completion levels and the display/status outputs.
interface bitcount_scheduler_if #(
    parameter int NREQ = 4,
    parameter int DW   = 8
);
    localparam int CW = $clog2(DW + 1);
    localparam int GW = $clog2(NREQ);

    // Four-phase handshake per requester i: raise req[i] with req_data slice i
    // stable, wait for done[i]=1, drop req[i], then done[i] returns to 0 before
    // the scheduler looks at any request again.
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    done;
    logic [CW-1:0]      result;
    logic [GW-1:0]      grant_id;
    logic               busy;
    logic [1:0]         state;

    modport master (
        output req, req_data,
        input  done, result, grant_id, busy, state
    );

    modport slave (
        input  req, req_data,
        output done, result, grant_id, busy, state
    );
endinterface

// File: rtl/bitcount_scheduler.sv
// Round-robin scheduler sharing one shift-and-count popcount unit among NREQ
// requesters. Define BITCNT_STATS_EN to add the serve_count/max_count outputs.
module bitcount_scheduler #(
    parameter int  NREQ = 4,
    parameter int  DW   = 8,
    localparam int CW   = $clog2(DW + 1),
    localparam int GW   = $clog2(NREQ)
) (
    input  logic                clock,
    input  logic                reset,
`ifdef BITCNT_STATS_EN
    output logic [7:0]          serve_count,
    output logic [CW-1:0]       max_count,
`endif
    bitcount_scheduler_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [NREQ-1:0] DONE_ONE = NREQ'(1);

    state_t          state_q;
    logic [GW-1:0]   grant_q;
    logic [GW-1:0]   rr_q;
    logic [DW-1:0]   shift_q;
    logic [CW-1:0]   result_q;
    logic [NREQ-1:0] done_q;

    logic [GW-1:0]   grant_d;
    logic [GW-1:0]   rr_d;
    logic            any_req;
    logic            release_done;

    // Descending scan so the smallest offset from rr_q is the last write and wins.
    always_comb begin
        int unsigned idx;
        idx     = 0;
        grant_d = rr_q;
        any_req = |bus.req;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = (int'(rr_q) + i) % NREQ;
            if (bus.req[idx]) begin
                grant_d = GW'(idx);
            end
        end
    end

    assign rr_d         = (grant_q == GW'(NREQ - 1)) ? '0 : grant_q + GW'(1);
    assign release_done = (state_q == DONE) && !bus.req[grant_q];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_q     <= '0;
            shift_q  <= '0;
            result_q <= '0;
            done_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        grant_q <= grant_d;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    shift_q  <= bus.req_data[grant_q*DW +: DW];
                    result_q <= '0;
                    state_q  <= COUNT;
                end
                COUNT: begin
                    // Stops as soon as no set bits remain above the current position.
                    if (shift_q == '0) begin
                        done_q  <= DONE_ONE << grant_q;
                        state_q <= DONE;
                    end else begin
                        result_q <= result_q + CW'(shift_q[0]);
                        shift_q  <= shift_q >> 1;
                    end
                end
                DONE: begin
                    if (!bus.req[grant_q]) begin
                        done_q  <= '0;
                        rr_q    <= rr_d;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    done_q  <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef BITCNT_STATS_EN
    logic [7:0]    serve_count_q;
    logic [CW-1:0] max_count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            serve_count_q <= '0;
            max_count_q   <= '0;
        end else if (release_done) begin
            serve_count_q <= serve_count_q + 8'd1;
            if (result_q > max_count_q) begin
                max_count_q <= result_q;
            end
        end
    end

    assign serve_count = serve_count_q;
    assign max_count   = max_count_q;
`endif

    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.grant_id = grant_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.state    = state_q;

endmodule

// File: tb/tb_bitcount_scheduler.sv
// Directed bench for bitcount_scheduler: a transaction-level reference model
// checked every cycle, plus hand-computed latency/result expectations.
module tb_bitcount_scheduler;
    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int CW   = $clog2(DW + 1);

    logic clock;
    logic reset;
    int   checks;
    int   failures;

    bitcount_scheduler_if #(.NREQ(NREQ), .DW(DW)) bus ();

`ifdef BITCNT_STATS_EN
    logic [7:0]    serve_count;
    logic [CW-1:0] max_count;
    bitcount_scheduler #(.NREQ(NREQ), .DW(DW)) dut (
        .clock      (clock),
        .reset      (reset),
        .serve_count(serve_count),
        .max_count  (max_count),
        .bus        (bus)
    );
`else
    bitcount_scheduler #(.NREQ(NREQ), .DW(DW)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );
`endif

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // reference model: phases numbered as the displayed state, timeline by counting
    int          m_phase;
    int          m_grant;
    int          m_rr;
    int          m_left;
    int          m_result;
    bit          m_res_valid;
    int          m_serve;
    int          m_max;
    logic [DW-1:0] m_op;

    always @(posedge clock) begin
        if (reset) begin
            m_phase = 0; m_grant = 0; m_rr = 0; m_left = 0;
            m_result = 0; m_res_valid = 1'b1; m_serve = 0; m_max = 0;
        end else begin
            case (m_phase)
                0: if (bus.req != '0) begin
                    for (int i = NREQ - 1; i >= 0; i--)
                        if (bus.req[(m_rr + i) % NREQ]) m_grant = (m_rr + i) % NREQ;
                    m_phase = 1;
                end
                1: begin
                    m_op = bus.req_data[m_grant*DW +: DW];
                    m_left = 1;
                    for (int b = 0; b < DW; b++) if (m_op[b]) m_left = b + 2;
                    m_result = $countones(m_op);
                    m_res_valid = 1'b0;
                    m_phase = 2;
                end
                2: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = 3;
                        m_res_valid = 1'b1;
                    end
                end
                default: if (!bus.req[m_grant]) begin
                    m_phase = 0;
                    m_rr = (m_grant + 1) % NREQ;
                    m_serve = (m_serve + 1) % 256;
                    if (m_result > m_max) m_max = m_result;
                end
            endcase
        end
        #1;
        check("state", bus.state, m_phase);
        check("busy", bus.busy, (m_phase != 0));
        check("done", bus.done, (m_phase == 3) ? (1 << m_grant) : 0);
        check("grant_id", bus.grant_id, m_grant);
        if (m_res_valid) check("result", bus.result, m_result);
`ifdef BITCNT_STATS_EN
        check("serve_count", serve_count, m_serve);
        check("max_count", max_count, m_max);
`endif
    end

    // driver tasks
    task automatic set_data(input int id, input logic [DW-1:0] d);
        bus.req_data[id*DW +: DW] = d;
    endtask

    task automatic wait_done(output int id, output int cyc);
        id  = -1;
        cyc = 0;
        while (id < 0 && cyc < 100) begin
            @(negedge clock);
            cyc++;
            for (int i = 0; i < NREQ; i++) if (bus.done[i]) id = i;
        end
        if (id < 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=none expected=done within 100 cycles");
        end
    endtask

    task automatic release_req(input int id);
        bus.req[id] = 1'b0;
        @(negedge clock);
    endtask

    task automatic serve(input string tag, input int id, input logic [DW-1:0] d,
                         input int exp_lat, input int exp_res);
        int got_id, cyc;
        set_data(id, d);
        bus.req[id] = 1'b1;
        wait_done(got_id, cyc);
        check({tag, "_id"}, got_id, id);
        check({tag, "_latency"}, cyc, exp_lat);
        check({tag, "_result"}, bus.result, exp_res);
        release_req(id);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset   = 1'b1;
        bus.req = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    int gid, cyc;
    int order[5] = '{0, 1, 2, 3, 0};

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        bus.req      = '0;
        bus.req_data = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check("rst_state", bus.state, 0);
        check("rst_done", bus.done, 0);
        check("rst_result", bus.result, 0);
        check("rst_busy", bus.busy, 0);

        // 0xB1: highest bit 7 -> 3+8 cycles, four ones
        set_data(0, 8'hB1);
        bus.req[0] = 1'b1;
        wait_done(gid, cyc);
        check("t1_id", gid, 0);
        check("t1_latency", cyc, 11);
        check("t1_result", bus.result, 4);
        check("t1_state", bus.state, 3);
        release_req(0);

        serve("t2", 1, 8'h00, 3, 0);
        check("t2_state_after", bus.state, 0);
        check("t2_done_after", bus.done, 0);

        // all four requesting, each re-raised after service
        do_reset();
        for (int i = 0; i < NREQ; i++) set_data(i, 8'hFF);
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_done(gid, cyc);
            check("t3_grant", gid, order[k]);
            check("t3_latency", cyc, 11);
            check("t3_result", bus.result, 8);
            if (k == 4) begin
                bus.req = '0;
                @(negedge clock);
            end else begin
                release_req(order[k]);
                bus.req[order[k]] = 1'b1;
            end
        end

        // pointer moves to 3 after serving 2; then 3 wins over 0
        serve("t4a", 2, 8'h05, 6, 2);
        set_data(3, 8'h80);
        set_data(0, 8'h01);
        bus.req = 4'b1001;
        wait_done(gid, cyc);
        check("t4_first", gid, 3);
        check("t4_first_latency", cyc, 11);
        check("t4_first_result", bus.result, 1);
        bus.req[3] = 1'b0;
        wait_done(gid, cyc);
        check("t4_second", gid, 0);
        check("t4_second_latency", cyc, 5);
        check("t4_second_result", bus.result, 1);
        release_req(0);

        // early drop, operand change after LOAD, short-lived foreign request
        set_data(3, 8'h0F);
        bus.req[3] = 1'b1;
        @(negedge clock);
        bus.req[1] = 1'b1;
        repeat (2) @(negedge clock);
        bus.req[1] = 1'b0;
        bus.req[3] = 1'b0;
        set_data(3, 8'hFF);
        wait_done(gid, cyc);
        check("drop_id", gid, 3);
        check("drop_latency", cyc, 4);
        check("drop_result", bus.result, 4);
        repeat (2) @(negedge clock);
        check("drop_state_after", bus.state, 0);
        check("drop_done_after", bus.done, 0);

        // reset in the middle of COUNT
        set_data(0, 8'hFF);
        bus.req[0] = 1'b1;
        repeat (4) @(negedge clock);
        check("t5_in_count", bus.state, 2);
        reset   = 1'b1;
        bus.req = '0;
        @(negedge clock);
        reset = 1'b0;
        check("t5_state", bus.state, 0);
        check("t5_result", bus.result, 0);
        check("t5_done", bus.done, 0);
        check("t5_busy", bus.busy, 0);
        serve("t5b", 2, 8'h0F, 7, 4);
        check("t5b_grant", bus.grant_id, 2);

`ifdef BITCNT_STATS_EN
        do_reset();
        serve("t6a", 0, 8'h03, 5, 2);
        serve("t6b", 1, 8'h7F, 10, 7);
        serve("t6c", 2, 8'h01, 4, 1);
        check("t6_serve_count", serve_count, 3);
        check("t6_max_count", max_count, 7);
`endif

        repeat (3) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "global timeout");
    end
endmodule
